// File: rtl/lane_rr_scheduler.sv
// lane_rr_fifo: per-lane word buffer with registered occupancy count.
// Latency: a pushed word becomes the head (visible to the reader) after the next edge.
// Backpressure: full_o is registered; pushes while full and pops while empty are dropped.
//   ports: clk, reset (sync, active-high), push_vld_i/push_dat_i write side,
//          pop_i read side, head_dat_o current head word, full_o/empty_o status.
module lane_rr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_en    = push_vld_i && !full_o;
  assign pop_en     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the natural pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_en && !reset) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// lane_rr_scheduler: round-robin grant of four lane FIFOs onto one registered output.
// Latency: word accepted at edge k into an empty system is on the output after edge k+1.
// Backpressure: out_ready_i low freezes the output stage and all FIFO heads; in_ready_o
//   ports: in_data_i/in_valid_i/in_ready_o per-lane inputs, out_data_o/out_lane_o/
//          out_valid_o/out_ready_i output stage, idle_o when nothing is buffered.
module lane_rr_scheduler #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DATA_W-1:0]   in_data_i,
  input  logic [3:0]            in_valid_i,
  output logic [3:0]            in_ready_o,
  output logic [DATA_W-1:0]     out_data_o,
  output logic                  out_valid_o,
  output logic [1:0]            out_lane_o,
  input  logic                  out_ready_i,
  output logic                  idle_o
);
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               ptr_q, ptr_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [1:0]               out_lane_q, out_lane_d;

  logic [3:0]               full, empty, push, pop;
  logic [3:0][DATA_W-1:0]   head;
  logic                     found;
  logic [1:0]               grant;
  logic [1:0]               idx;

  // in_ready follows the registered count only, so a same-cycle pop never raises it.
  assign in_ready_o = ~full & {4{~reset}};
  assign push       = in_valid_i & in_ready_o;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_rr_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_vld_i (push[i]),
      .push_dat_i (in_data_i[i*DATA_W +: DATA_W]),
      .pop_i      (pop[i]),
      .head_dat_o (head[i]),
      .full_o     (full[i]),
      .empty_o    (empty[i])
    );
  end

  // First non-empty lane starting at ptr; uses registered counts, so words
  // pushed this cycle are not yet eligible.
  always_comb begin
    found = 1'b0;
    grant = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_lane_d = out_lane_q;
    pop        = 4'b0000;
    // Output stage loads when empty or when its word leaves this cycle.
    if (state_q == ST_EMPTY || out_ready_i) begin
      if (found) begin
        state_d    = ST_FULL;
        pop        = 4'b0001 << grant;
        out_data_d = head[grant];
        out_lane_d = grant;
        ptr_d      = grant + 2'd1;
      end else begin
        state_d    = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      ptr_q      <= 2'd0;
      out_data_q <= '0;
      out_lane_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_lane_q <= out_lane_d;
    end
  end

  assign out_valid_o = (state_q == ST_FULL);
  assign out_data_o  = out_data_q;
  assign out_lane_o  = out_lane_q;
  assign idle_o      = (&empty) && !out_valid_o;
endmodule

// File: tb/tb_lane_rr_scheduler.sv
module tb_lane_rr_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_lane;
  logic        out_ready;
  logic        idle;

  int total = 0;
  int bad   = 0;

  lane_rr_scheduler #(.DATA_W(8), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_lane_o  (out_lane),
    .out_ready_i (out_ready),
    .idle_o      (idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 4'b0000;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 4'b1111;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (out_lane !== 2'd0) begin bad++; $display("FAIL reset_out_lane got=%0d exp=0", out_lane); end
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    reset    = 1'b0;
    in_valid = 4'b0000;
    #1;
    total++; if (in_ready !== 4'b1111) begin bad++; $display("FAIL release_in_ready got=%b exp=1111", in_ready); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL release_idle got=%b exp=1", idle); end
  endtask

  task automatic test_single_word();
    do_reset();
    out_ready        = 1'b1;
    in_valid         = 4'b0100;
    in_data[16 +: 8] = 8'hA5;
    step();
    in_valid = 4'b0000;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_cycle1_valid got=%b exp=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_cycle2_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", out_data); end
    total++; if (out_lane !== 2'd2) begin bad++; $display("FAIL single_lane got=%0d exp=2", out_lane); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_cycle3_valid got=%b exp=0", out_valid); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_dat [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    logic [1:0] exp_lane [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h13121110;
    step();
    in_data   = 32'h23222120;
    step();
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_dat[i] || out_lane !== exp_lane[i]) begin
        bad++;
        $display("FAIL rr_word%0d got v=%b d=%h l=%0d exp v=1 d=%h l=%0d", i, out_valid, out_data, out_lane, exp_dat[i], exp_lane[i]);
      end
      step();
    end
    total++; if (out_valid !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL rr_drain got v=%b idle=%b exp v=0 idle=1", out_valid, idle); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_dat [3] = '{8'h40, 8'h41, 8'h42};
    do_reset();
    out_ready       = 1'b0;
    in_valid        = 4'b0010;
    in_data[8 +: 8] = 8'h40;
    total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b exp=1", in_ready[1]); end
    step();
    in_data[8 +: 8] = 8'h41;
    total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready[1]); end
    step();
    in_data[8 +: 8] = 8'h42;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h40 || out_lane !== 2'd1) begin
      bad++; $display("FAIL bp_first got v=%b d=%h l=%0d exp v=1 d=40 l=1", out_valid, out_data, out_lane);
    end
    total++; if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_ready2 got=%b exp=1", in_ready[1]); end
    step();
    in_data[8 +: 8] = 8'h43;
    for (int i = 0; i < 6; i++) begin
      total++; if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_full%0d got=%b exp=0", i, in_ready[1]); end
      total++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin
        bad++; $display("FAIL bp_stall%0d got v=%b d=%h exp v=1 d=40", i, out_valid, out_data);
      end
      step();
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_dat[i] || out_lane !== 2'd1) begin
        bad++; $display("FAIL bp_drain%0d got v=%b d=%h l=%0d exp v=1 d=%h l=1", i, out_valid, out_data, out_lane, exp_dat[i]);
      end
      step();
    end
    total++; if (out_valid !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL bp_end got v=%b idle=%b exp v=0 idle=1", out_valid, idle); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_l;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b1001;
    in_data   = 32'h3300_0000 | 32'h0000_0050;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      exp_l = (i % 2 == 0) ? 2'd0 : 2'd3;
      total++; if (out_valid !== 1'b1 || out_lane !== exp_l) begin
        bad++; $display("FAIL fair_grant%0d got v=%b l=%0d exp v=1 l=%0d", i, out_valid, out_lane, exp_l);
      end
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b1101;
    in_data   = 32'h6362_0061;
    step();
    in_valid  = 4'b0000;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin
      bad++; $display("FAIL mid_held got v=%b d=%h exp v=1 d=61", out_valid, out_data);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_idle got=%b exp=1", idle); end
    total++; if (in_ready !== 4'b1111) begin bad++; $display("FAIL mid_ready got=%b exp=1111", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin
        bad++; $display("FAIL mid_ghost%0d got v=%b d=%h exp v=0", i, out_valid, out_data);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b0000;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
